// File: rtl/player_stepper.sv
// Per-player light-cycle movement engine: steps a one-hot X/Y position once per game
// tick, exposes the vacated cell as the new trail cell, and handles crash/reload.
module player_stepper #(
  parameter int unsigned GRID_W    = 32,
  parameter int unsigned GRID_H    = 32,
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned START_X   = 16,
  parameter int unsigned START_Y   = 16,
  parameter logic [1:0]  START_DIR = 2'b01
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic [1:0]        dir_req,
  input  logic              dir_valid,
  input  logic              hit,
  output logic [GRID_W-1:0] loc_x,
  output logic [GRID_H-1:0] loc_y,
  output logic [GRID_W-1:0] wall_x,
  output logic [GRID_H-1:0] wall_y,
  output logic              step_en,
  output logic [1:0]        state,
  output logic              crashed
);

  localparam int unsigned       CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [GRID_W-1:0] HOME_X   = GRID_W'(1) << START_X;
  localparam logic [GRID_H-1:0] HOME_Y   = GRID_H'(1) << START_Y;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CRASH = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GRID_W-1:0] loc_x_d, wall_x_d;
  logic [GRID_H-1:0] loc_y_d, wall_y_d;
  logic              step_en_d;
  logic              crashed_d;

  logic [1:0]        pend_acc;
  logic              off_grid;
  logic [GRID_W-1:0] moved_x;
  logic [GRID_H-1:0] moved_y;

  assign state = state_q;

  // Heading to use at the coming tick: a request in this very cycle still counts.
  always_comb begin
    pend_acc = pend_q;
    if (dir_valid && (dir_req != (dir_q ^ 2'b10))) begin
      pend_acc = dir_req;
    end
  end

  // Candidate move in the pending heading, and whether it would leave the grid.
  always_comb begin
    moved_x  = loc_x;
    moved_y  = loc_y;
    off_grid = 1'b0;
    case (pend_acc)
      DIR_UP: begin
        moved_y  = loc_y >> 1;
        off_grid = loc_y[0];
      end
      DIR_RIGHT: begin
        moved_x  = loc_x << 1;
        off_grid = loc_x[GRID_W-1];
      end
      DIR_DOWN: begin
        moved_y  = loc_y << 1;
        off_grid = loc_y[GRID_H-1];
      end
      DIR_LEFT: begin
        moved_x  = loc_x >> 1;
        off_grid = loc_x[0];
      end
      default: begin
        moved_x  = loc_x;
        moved_y  = loc_y;
        off_grid = 1'b0;
      end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    loc_x_d   = loc_x;
    loc_y_d   = loc_y;
    wall_x_d  = wall_x;
    wall_y_d  = wall_y;
    step_en_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        pend_d = pend_acc;
        if (hit) begin
          state_d = ST_CRASH;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          dir_d = pend_acc;
          if (off_grid) begin
            state_d = ST_CRASH;
          end else begin
            wall_x_d  = loc_x;
            wall_y_d  = loc_y;
            loc_x_d   = moved_x;
            loc_y_d   = moved_y;
            step_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CRASH: begin
        if (start) begin
          state_d  = ST_IDLE;
          loc_x_d  = HOME_X;
          loc_y_d  = HOME_Y;
          wall_x_d = '0;
          wall_y_d = '0;
          dir_d    = START_DIR;
          pend_d   = START_DIR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    crashed_d = (state_d == ST_CRASH);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q <= ST_IDLE;
      dir_q   <= START_DIR;
      pend_q  <= START_DIR;
      cnt_q   <= '0;
      loc_x   <= HOME_X;
      loc_y   <= HOME_Y;
      wall_x  <= '0;
      wall_y  <= '0;
      step_en <= 1'b0;
      crashed <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      loc_x   <= loc_x_d;
      loc_y   <= loc_y_d;
      wall_x  <= wall_x_d;
      wall_y  <= wall_y_d;
      step_en <= step_en_d;
      crashed <= crashed_d;
    end
  end

endmodule

// File: tb/tb_player_stepper.sv
// Bench for player_stepper: integer-coordinate game model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_player_stepper;

  localparam int GW = 32;
  localparam int GH = 32;
  localparam int TD = 4;
  localparam int SX = 16;
  localparam int SY = 16;
  localparam int SD = 1;

  logic          clk = 1'b0;
  logic          clrn = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    dir_req = 2'b00;
  logic          dir_valid = 1'b0;
  logic          hit = 1'b0;
  logic [GW-1:0] loc_x, wall_x;
  logic [GH-1:0] loc_y, wall_y;
  logic          step_en;
  logic [1:0]    state;
  logic          crashed;

  int vectors = 0;
  int errors  = 0;

  player_stepper #(
    .GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD),
    .START_X(SX), .START_Y(SY), .START_DIR(2'b01)
  ) dut (
    .clk(clk), .clrn(clrn), .start(start), .dir_req(dir_req),
    .dir_valid(dir_valid), .hit(hit), .loc_x(loc_x), .loc_y(loc_y),
    .wall_x(wall_x), .wall_y(wall_y), .step_en(step_en),
    .state(state), .crashed(crashed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] oh(input int i);
    logic [31:0] one;
    one = 32'd1;
    return (i < 0) ? 32'd0 : (one << i);
  endfunction

  function automatic int dx(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int dy(input int d);
    return (d == 0) ? -1 : (d == 2) ? 1 : 0;
  endfunction

  // Game model: coordinates as integers, wall = -1 when no trail cell exists.
  int mx, my, mwx, mwy, mdir, mpend, mst, mcnt;
  bit mstep;

  always @(posedge clk or posedge clrn) begin
    int nx, ny;
    if (clrn) begin
      mx = SX; my = SY; mwx = -1; mwy = -1;
      mdir = SD; mpend = SD; mst = 0; mcnt = 0; mstep = 0;
    end else begin
      mstep = 0;
      if (mst == 0) begin
        if (start) begin mst = 1; mcnt = 0; end
      end else if (mst == 1) begin
        if (dir_valid && int'(dir_req) != (mdir ^ 2)) mpend = int'(dir_req);
        if (hit) begin
          mst = 2;
        end else if (mcnt == TD - 1) begin
          mcnt = 0;
          mdir = mpend;
          nx = mx + dx(mdir);
          ny = my + dy(mdir);
          if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            mst = 2;
          end else begin
            mwx = mx; mwy = my; mx = nx; my = ny; mstep = 1;
          end
        end else begin
          mcnt++;
        end
      end else begin
        if (start) begin
          mst = 0; mx = SX; my = SY; mwx = -1; mwy = -1; mdir = SD; mpend = SD;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("m.loc_x", loc_x, oh(mx));
    check("m.loc_y", loc_y, oh(my));
    check("m.wall_x", wall_x, oh(mwx));
    check("m.wall_y", wall_y, oh(mwy));
    check("m.step_en", 32'(step_en), 32'(mstep));
    check("m.state", 32'(state), 32'(mst));
    check("m.crashed", 32'(crashed), 32'(mst == 2));
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic request(input logic [1:0] d);
    @(negedge clk) begin dir_req = d; dir_valid = 1'b1; end
    @(negedge clk) dir_valid = 1'b0;
  endtask

  // Wait for the next step_en pulse; n returns how many edges that took.
  task automatic wait_step(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      n++;
      if (step_en) break;
    end
    if (!step_en) check("step timeout", 32'(step_en), 32'd1);
  endtask

  task automatic wait_crash();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (state == 2'b10) break;
    end
  endtask

  // Move to the negedge of the terminal-count cycle following a step just seen.
  task automatic to_terminal();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int seen;
    // Reset
    repeat (2) @(negedge clk);
    #2;
    check("rst loc_x", loc_x, 32'h0001_0000);
    check("rst loc_y", loc_y, 32'h0001_0000);
    check("rst wall_x", wall_x, 32'h0);
    check("rst wall_y", wall_y, 32'h0);
    check("rst state", 32'(state), 32'd0);
    check("rst step_en", 32'(step_en), 32'd0);
    @(negedge clk) clrn = 1'b0;
    repeat (2) @(negedge clk);

    // Run: three steps four edges apart
    pulse_start();
    wait_step(n);
    check("run gap1", 32'(n), 32'd4);
    check("run1 loc_x", loc_x, 32'h0002_0000);
    check("run1 wall_x", wall_x, 32'h0001_0000);
    check("run1 loc_y", loc_y, 32'h0001_0000);
    wait_step(n);
    check("run gap2", 32'(n), 32'd4);
    wait_step(n);
    check("run gap3", 32'(n), 32'd4);
    check("run3 loc_x", loc_x, 32'h0008_0000);

    // Turning: reversal rejected, then turn down
    request(2'b11);
    wait_step(n);
    check("rev loc_x", loc_x, 32'h0010_0000);
    request(2'b10);
    wait_step(n);
    check("turn loc_y", loc_y, 32'h0002_0000);
    check("turn wall_y", wall_y, 32'h0001_0000);
    check("turn loc_x", loc_x, 32'h0010_0000);

    // Request in the terminal cycle itself takes effect at that tick
    to_terminal();
    dir_req = 2'b01; dir_valid = 1'b1;
    @(negedge clk) dir_valid = 1'b0;
    check("same-tick step", 32'(step_en), 32'd1);
    check("same-tick loc_x", loc_x, 32'h0020_0000);
    check("same-tick loc_y", loc_y, 32'h0002_0000);

    // Right boundary: x 21 -> 31, then crash with no step
    for (int i = 0; i < 10; i++) wait_step(n);
    check("edge loc_x", loc_x, 32'h8000_0000);
    wait_crash();
    check("edge state", 32'(state), 32'd2);
    check("edge crashed", 32'(crashed), 32'd1);
    check("edge step_en", 32'(step_en), 32'd0);
    check("edge loc_x hold", loc_x, 32'h8000_0000);

    // Reload
    pulse_start();
    check("reload state", 32'(state), 32'd0);
    check("reload loc_x", loc_x, 32'h0001_0000);
    check("reload loc_y", loc_y, 32'h0001_0000);
    check("reload wall_x", wall_x, 32'h0);
    check("reload wall_y", wall_y, 32'h0);

    // hit on the terminal edge beats the step
    pulse_start();
    wait_step(n);
    to_terminal();
    hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    check("hit state", 32'(state), 32'd2);
    check("hit crashed", 32'(crashed), 32'd1);
    check("hit step_en", 32'(step_en), 32'd0);
    check("hit loc_x", loc_x, 32'h0002_0000);
    check("hit wall_x", wall_x, 32'h0001_0000);
    pulse_start();

    // dir_valid in IDLE is ignored; then head up into the top edge
    request(2'b10);
    pulse_start();
    wait_step(n);
    check("idle-dir loc_x", loc_x, 32'h0002_0000);
    check("idle-dir loc_y", loc_y, 32'h0001_0000);
    request(2'b00);
    for (int i = 0; i < 16; i++) wait_step(n);
    check("top loc_y", loc_y, 32'h0000_0001);
    check("top loc_x", loc_x, 32'h0002_0000);
    wait_crash();
    check("top state", 32'(state), 32'd2);
    check("top loc_y hold", loc_y, 32'h0000_0001);
    pulse_start();

    // Mid-run asynchronous reset
    pulse_start();
    wait_step(n);
    repeat (2) @(negedge clk);
    #2 clrn = 1'b1;
    #1;
    check("arst loc_x", loc_x, 32'h0001_0000);
    check("arst loc_y", loc_y, 32'h0001_0000);
    check("arst wall_x", wall_x, 32'h0);
    check("arst state", 32'(state), 32'd0);
    check("arst crashed", 32'(crashed), 32'd0);
    check("arst step_en", 32'(step_en), 32'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (step_en || state != 2'b00) seen++;
    end
    check("post-rst quiet", 32'(seen), 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/player_stepper.md
# player_stepper

Per-player movement engine for the two-player light-cycle game. Once per game tick it advances the player's one-hot X/Y position by one cell in the current heading. It presents the vacated cell as the new wall (trail) cell and pulses an update strobe. Its outputs feed the per-player location/wall capture registers of the grid stage directly: `loc_x/loc_y` → `LOC_pN_xi/yi`, `wall_x/wall_y` → `wall_pN_xi/yi`, `step_en` → `enableN`. The design instantiates one stepper per player.

## Interface
Parameters:
- `GRID_W`, 32: grid width, i.e. the `loc_x`/`wall_x` width.
- `GRID_H`, 32: grid height, i.e. the `loc_y`/`wall_y` width.
- `TICK_DIV`, 4: clock cycles per game step. Must be ≥ 2.
- `START_X`, 16: start column index, 0..GRID_W-1.
- `START_Y`, 16: start row index, 0..GRID_H-1.
- `START_DIR`, 2'b01: heading at reset and on reload.

Ports:
- `clk`, in, 1: clock.
- `clrn`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: single-cycle request; IDLE→RUN, or CRASH→IDLE with reload.
- `dir_req`, in, 2: requested heading. 00 up (y−1), 01 right (x+1), 10 down (y+1), 11 left (x−1).
- `dir_valid`, in, 1: qualifies `dir_req`.
- `hit`, in, 1: external collision flag from the trail/opponent check.
- `loc_x`, out, GRID_W: one-hot current column.
- `loc_y`, out, GRID_H: one-hot current row.
- `wall_x`, out, GRID_W: one-hot column of the cell vacated by the last step.
- `wall_y`, out, GRID_H: one-hot row of the cell vacated by the last step.
- `step_en`, out, 1: one-cycle strobe; loc/wall hold newly stepped values.
- `state`, out, 2: 00 IDLE, 01 RUN, 10 CRASH.
- `crashed`, out, 1: high while in CRASH.

## Operation
- Registers:
  - `state`
  - `dir` (2 bits)
  - `pend_dir` (2 bits)
  - tick counter `cnt`, width clog2(TICK_DIV)
  - `loc_x`/`loc_y`/`wall_x`/`wall_y`
  - `step_en`
- Reset values (asserted asynchronously by `clrn`):
  - `state` = IDLE; `dir` = `pend_dir` = START_DIR; `cnt` = 0
  - `loc_x` = 1<<START_X; `loc_y` = 1<<START_Y
  - `wall_x` = `wall_y` = 0
  - `step_en` = 0; `crashed` = 0
- IDLE: outputs hold. On `start`, go to RUN with `cnt` = 0. `dir_valid` is ignored.
- RUN:
  - `cnt` increments each cycle and wraps to 0 after TICK_DIV−1.
  - `dir_valid` with `dir_req` ≠ (`dir` XOR 2'b10) loads `pend_dir`. A reversal is rejected and `pend_dir` is unchanged. The last accepted request before a tick wins.
  - Terminal edge (`cnt` == TICK_DIV−1), with `hit` low:
    - `dir` ← `pend_dir`.
    - If the move in `pend_dir` would leave the grid, go to CRASH with no position update and `step_en` staying 0. Leaving the grid means: `loc_x[0]` and left; `loc_x[GRID_W−1]` and right; `loc_y[0]` and up; `loc_y[GRID_H−1]` and down.
    - Otherwise `wall` ← `loc`, `loc` ← `loc` shifted one position, and `step_en` ← 1.
  - `hit` high at any edge in RUN: go to CRASH. `hit` has priority over a simultaneous terminal tick, so there is no step and no `dir` update.
- CRASH:
  - All position outputs hold; `crashed` = 1; `step_en` = 0.
  - `start` → IDLE, reloading `loc` to the start cell, clearing `wall` to 0, and setting `dir`/`pend_dir` to START_DIR.
- `start` in RUN is ignored.
- Invariant: `loc_x` and `loc_y` are always exactly one-hot. `wall_x`/`wall_y` are either all-zero (before the first step or after a reload) or one-hot.

## Timing
- The edge that samples `start` in IDLE moves `state` to RUN. The first step edge comes TICK_DIV edges later, and steps then repeat every TICK_DIV cycles.
- `step_en` is registered. It is high for exactly the one cycle following a step edge, the same cycle in which the new `loc`/`wall` become visible, so the grid captures them on the next edge.
- Latency:
  - `dir_valid` to effect: the request is applied at the next terminal tick, even when it arrives in the same cycle as that tick.
  - `hit` to `crashed`: 1 edge.
- `clrn` mid-RUN: all registers take their reset values immediately, asynchronously. There is no pending step after release.
- `state` and `crashed` change only on `clk` edges, except under `clrn`.

## Test plan
Default parameters unless stated.
- **Reset:** assert `clrn`. Expect `loc_x` = 32'h0001_0000, `loc_y` = 32'h0001_0000, `wall_x` = `wall_y` = 0, `state` = 00, `step_en` = 0.
- **Run:** pulse `start` and run 12 cycles.
  - `step_en` pulses every 4 cycles.
  - After the first pulse: `loc_x` = 1<<17, `wall_x` = 1<<16, `loc_y` unchanged.
  - After the third pulse: `loc_x` = 1<<19.
- **Turning:** in RUN heading right, `dir_req` = 11 (reversal) with `dir_valid`, then a tick: `loc_x` still advances right. Then `dir_req` = 10 before the next tick: `loc_y` = 1<<17, `wall_y` = 1<<16, `loc_x` unchanged.
- **Boundary:** START_X = 30, heading right.
  - First step: `loc_x` = 1<<31.
  - Next terminal tick: `state` = 10, `crashed` = 1, no `step_en`, `loc_x` remains 1<<31.
- **hit priority:** assert `hit` on the same edge as the terminal count. Expect `state` = 10, no `step_en`, `loc` unchanged.
- **Reload and mid-run reset:**
  - From CRASH, pulse `start`: `state` = 00, `loc` = start cell, `wall` = 0.
  - Then `start`, wait 2 cycles, assert `clrn`: all outputs take their reset values immediately, and no `step_en` follows release.
